// File: rtl/seq_subtractor.sv
// -----------------------------------------------------------------------------
// seq_subtractor
//
// Multi-cycle unsigned subtractor: diff = a - b - bin over WIDTH bits, DIGIT
// bits per clock, with the borrow carried between digits in a flop.
// A two-state FSM (IDLE/RUN) runs each operation in N = WIDTH/DIGIT cycles
// behind a start/done handshake.
//
// Parameters
//   WIDTH  operand/result width (>= 1)
//   DIGIT  bits processed per clock (1..WIDTH, WIDTH % DIGIT == 0)
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted while busy = 0
//   a      in   minuend, sampled with start
//   b      in   subtrahend, sampled with start
//   bin    in   borrow-in, sampled with start
//   busy   out  operation in progress
//   done   out  one-cycle pulse, diff/bout valid
//   diff   out  result, held until the next operation overwrites it
//   bout   out  final borrow-out (1 means a < b + bin)
//
// Configuration macro
//   SEQ_SUB_SAT_EN  when defined, a final borrow forces diff to 0 (unsigned
//                   floor saturation); bout still reports the borrow.
// -----------------------------------------------------------------------------
module seq_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("seq_subtractor: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             brw_q,   brw_d;
    logic [WIDTH-1:0] diff_q,  diff_d;
    logic             bout_q,  bout_d;
    logic             done_q,  done_d;

    // One digit of the subtraction. Operands are shifted right each RUN
    // cycle, so the current digit always sits in the low DIGIT bits; the
    // extra MSB of the DIGIT+1 result is the borrow out of this digit.
    logic [DIGIT:0]   dig_full;
    logic [DIGIT-1:0] dig_d;
    logic             dig_brw;

    always_comb begin
        dig_full = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};
        dig_d    = dig_full[DIGIT-1:0];
        dig_brw  = dig_full[DIGIT];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                end
            end

            S_RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                brw_d = dig_brw;

                // Write only the digit slot selected by the counter so the
                // previous result stays intact until its digits are replaced.
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k)) begin
                        diff_d[k*DIGIT +: DIGIT] = dig_d;
                    end
                end

                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    bout_d  = dig_brw;
`ifdef SEQ_SUB_SAT_EN
                    if (dig_brw) begin
                        diff_d = '0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_seq_subtractor.sv
// -----------------------------------------------------------------------------
// tb_seq_subtractor
//
// Directed bench for seq_subtractor with three instances:
//   u1  : WIDTH=1,  DIGIT=1  (registered full subtractor, N=1)
//   u8  : WIDTH=8,  DIGIT=4  (N=2)
//   u16 : WIDTH=16, DIGIT=4  (N=4)
// Expected values are hand-computed constants; SEQ_SUB_SAT_EN selects the
// saturated expectations where a final borrow occurs.
// -----------------------------------------------------------------------------
module tb_seq_subtractor;

    logic clk;
    logic rst_n;

    logic        s1, a1, b1, i1, busy1, done1, d1, bo1;
    logic        s8, i8, busy8, done8, bo8;
    logic [7:0]  a8, b8, d8;
    logic        s16, i16, busy16, done16, bo16;
    logic [15:0] a16, b16, d16;

    int n_tests;
    int n_fail;

    seq_subtractor #(.WIDTH(1), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .bin(i1),
        .busy(busy1), .done(done1), .diff(d1), .bout(bo1)
    );

    seq_subtractor #(.WIDTH(8), .DIGIT(4)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(i8),
        .busy(busy8), .done(done8), .diff(d8), .bout(bo8)
    );

    seq_subtractor #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16), .bin(i16),
        .busy(busy16), .done(done16), .diff(d16), .bout(bo16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---- instance access -------------------------------------------------
    task automatic drive(input int sel, input logic st, input logic [15:0] a,
                         input logic [15:0] b, input logic bin);
        case (sel)
            1:       begin s1  = st; a1  = a[0];   b1  = b[0];   i1  = bin; end
            8:       begin s8  = st; a8  = a[7:0]; b8  = b[7:0]; i8  = bin; end
            default: begin s16 = st; a16 = a;      b16 = b;      i16 = bin; end
        endcase
    endtask

    function automatic logic f_done(input int sel);
        case (sel)
            1:       return done1;
            8:       return done8;
            default: return done16;
        endcase
    endfunction

    function automatic logic f_busy(input int sel);
        case (sel)
            1:       return busy1;
            8:       return busy8;
            default: return busy16;
        endcase
    endfunction

    function automatic logic [15:0] f_diff(input int sel);
        case (sel)
            1:       return {15'b0, d1};
            8:       return {8'b0, d8};
            default: return d16;
        endcase
    endfunction

    function automatic logic f_bout(input int sel);
        case (sel)
            1:       return bo1;
            8:       return bo8;
            default: return bo16;
        endcase
    endfunction

    // Runs one operation. cyc = edges from the start edge to done (-1 on
    // timeout), bcyc = cycles busy was seen high. Returns in the done cycle.
    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, output logic [15:0] d, output logic bo,
                          output int cyc, output int bcyc);
        @(negedge clk);
        drive(sel, 1'b1, a, b, bin);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, a, b, bin);
        bcyc = f_busy(sel) ? 1 : 0;
        cyc  = -1;
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (f_done(sel)) begin
                cyc = c;
                break;
            end
            if (f_busy(sel)) bcyc++;
        end
        d  = f_diff(sel);
        bo = f_bout(sel);
    endtask

    // ---- tests -----------------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0;
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(16, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy1, done1, d1, bo1} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_w1: got busy=%b done=%b diff=%b bout=%b, want all 0", busy1, done1, d1, bo1);
        end
        n_tests++;
        if ({busy8, done8, d8, bo8} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_w8: got busy=%b done=%b diff=%h bout=%b, want all 0", busy8, done8, d8, bo8);
        end
        n_tests++;
        if ({busy16, done16, d16, bo16} !== 19'b0) begin
            n_fail++;
            $display("FAIL reset_w16: got busy=%b done=%b diff=%h bout=%b, want all 0", busy16, done16, d16, bo16);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_subtractor;
        logic [7:0]  exp_d;
        logic [7:0]  exp_b;
        logic [2:0]  v;
        logic [15:0] d;
        logic        bo;
        int          cyc, bcyc;
        // index = {a, b, bin}
        exp_b = 8'b1000_1110;
`ifdef SEQ_SUB_SAT_EN
        exp_d = 8'b0001_0000;
`else
        exp_d = 8'b1001_0110;
`endif
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            run_op(1, {15'b0, v[2]}, {15'b0, v[1]}, v[0], d, bo, cyc, bcyc);
            n_tests++;
            if (d[0] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL fullsub_diff abc=%b: got %b, want %b", v, d[0], exp_d[i]);
            end
            n_tests++;
            if (bo !== exp_b[i]) begin
                n_fail++;
                $display("FAIL fullsub_bout abc=%b: got %b, want %b", v, bo, exp_b[i]);
            end
            n_tests++;
            if (cyc !== 1) begin
                n_fail++;
                $display("FAIL fullsub_latency abc=%b: got %0d, want 1", v, cyc);
            end
        end
    endtask

    task automatic test_digit8;
        logic [15:0] d;
        logic [15:0] exp;
        logic        bo;
        int          cyc, bcyc;
        run_op(8, 16'h0035, 16'h0012, 1'b0, d, bo, cyc, bcyc);
        n_tests++;
        if (d !== 16'h0023 || bo !== 1'b0) begin
            n_fail++;
            $display("FAIL w8_basic: got diff=%h bout=%b, want diff=0023 bout=0", d, bo);
        end
        n_tests++;
        if (cyc !== 2) begin
            n_fail++;
            $display("FAIL w8_latency: got %0d, want 2", cyc);
        end
        run_op(8, 16'h0000, 16'h0001, 1'b0, d, bo, cyc, bcyc);
`ifdef SEQ_SUB_SAT_EN
        exp = 16'h0000;
`else
        exp = 16'h00FF;
`endif
        n_tests++;
        if (d !== exp || bo !== 1'b1) begin
            n_fail++;
            $display("FAIL w8_underflow: got diff=%h bout=%b, want diff=%h bout=1", d, bo, exp);
        end
    endtask

    task automatic test_borrow_chain;
        logic [15:0] d;
        logic        bo;
        int          cyc, bcyc;
        run_op(16, 16'h1000, 16'h0001, 1'b1, d, bo, cyc, bcyc);
        n_tests++;
        if (d !== 16'h0FFE || bo !== 1'b0) begin
            n_fail++;
            $display("FAIL w16_chain: got diff=%h bout=%b, want diff=0ffe bout=0", d, bo);
        end
        n_tests++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL w16_latency: got %0d, want 4", cyc);
        end
        n_tests++;
        if (bcyc !== 4) begin
            n_fail++;
            $display("FAIL w16_busy_cycles: got %0d, want 4", bcyc);
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (done16 !== 1'b0) begin
            n_fail++;
            $display("FAIL w16_done_pulse: got done=%b one cycle later, want 0", done16);
        end
    endtask

    task automatic test_ignore_start;
        int cyc;
        int extra_done;
        int extra_busy;
        @(negedge clk);
        drive(16, 1'b1, 16'h1234, 16'h0034, 1'b0);
        @(posedge clk);                       // E0
        @(negedge clk);
        drive(16, 1'b0, 16'h1234, 16'h0034, 1'b0);
        @(posedge clk);                       // E1
        @(negedge clk);
        drive(16, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        @(posedge clk);                       // E2, start must be ignored
        @(negedge clk);
        drive(16, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
        cyc = -1;
        for (int c = 3; c <= 32; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done16) begin
                cyc = c;
                break;
            end
        end
        n_tests++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d, want 4", cyc);
        end
        n_tests++;
        if (d16 !== 16'h1200 || bo16 !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result: got diff=%h bout=%b, want diff=1200 bout=0", d16, bo16);
        end
        extra_done = 0;
        extra_busy = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done16) extra_done++;
            if (busy16) extra_busy++;
        end
        n_tests++;
        if (extra_done !== 0 || extra_busy !== 0) begin
            n_fail++;
            $display("FAIL ignore_extra: got %0d extra done, %0d busy cycles, want 0 and 0", extra_done, extra_busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] d;
        logic        bo;
        int          cyc, bcyc;
        run_op(8, 16'h0035, 16'h0012, 1'b0, d, bo, cyc, bcyc);
        n_tests++;
        if (d !== 16'h0023 || cyc !== 2) begin
            n_fail++;
            $display("FAIL b2b_first: got diff=%h cyc=%0d, want diff=0023 cyc=2", d, cyc);
        end
        // still in the done cycle: request the next operation now
        drive(8, 1'b1, 16'h00FF, 16'h000F, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 16'h00FF, 16'h000F, 1'b0);
        n_tests++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", busy8, done8);
        end
        cyc = -1;
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                cyc = c;
                break;
            end
        end
        n_tests++;
        if (cyc !== 2) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d, want 2", cyc);
        end
        n_tests++;
        if (d8 !== 8'hF0 || bo8 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got diff=%h bout=%b, want diff=f0 bout=0", d8, bo8);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] d;
        logic        bo;
        int          cyc, bcyc;
        int          dones;
        // u16 currently holds 0x1200 from earlier, so a cleared diff is visible
        @(negedge clk);
        drive(16, 1'b1, 16'h1234, 16'h0001, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(16, 1'b0, 16'h1234, 16'h0001, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy16 !== 1'b0 || done16 !== 1'b0 || d16 !== 16'h0000 || bo16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b diff=%h bout=%b, want all 0", busy16, done16, d16, bo16);
        end
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done16 || busy16) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL reset_hold: got %0d cycles with done/busy, want 0", dones);
        end
        rst_n = 1'b1;
        run_op(16, 16'h0080, 16'h0001, 1'b0, d, bo, cyc, bcyc);
        n_tests++;
        if (d !== 16'h007F || bo !== 1'b0 || cyc !== 4) begin
            n_fail++;
            $display("FAIL reset_after: got diff=%h bout=%b cyc=%0d, want diff=007f bout=0 cyc=4", d, bo, cyc);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_full_subtractor();
        test_digit8();
        test_borrow_chain();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
